lmsm_sequencer: RTL and testbench

//  Micro-sequencer for LM (opcode 4'b0110) and SM (4'b0111) in the 16-bit RISC pipeline, placed at ID/RR.

---
 rtl/lmsm_sequencer_if.sv | 30 +++
 rtl/lmsm_sequencer.sv | 133 +++++++++++++
 tb/tb_lmsm_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// Micro-op bus between the LM/SM sequencer (master) and the load/store path (slave).
// Carries one load/store micro-op per cycle with a valid/ready handshake.
interface lmsm_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              uop_valid;
  logic              uop_ready;
  logic              uop_is_load;
  logic [2:0]        uop_reg;
  logic [ADDR_W-1:0] uop_addr;
  logic              uop_last;

  modport master (
    output uop_valid,
    output uop_is_load,
    output uop_reg,
    output uop_addr,
    output uop_last,
    input  uop_ready
  );

  modport slave (
    input  uop_valid,
    input  uop_is_load,
    input  uop_reg,
    input  uop_addr,
    input  uop_last,
    output uop_ready
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM micro-sequencer at ID/RR of the 16-bit RISC pipeline.
// Expands one LM (0110) or SM (0111) into one load/store micro-op per set bit
// of imm8, R0 (imm8[7]) first, with consecutive word addresses from RA.
// Optional feature macro: LMSM_STAT_EN enables the completed micro-op counter
// on stat_uop_cnt; without it the port is tied to zero.
module lmsm_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_in,
  input  logic              instr_valid,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  lmsm_sequencer_if.master  uop,
  output logic              busy,
  output logic              is_imm_zero_lm,
  output logic              is_imm_zero_sm,
  output logic [STAT_W-1:0] stat_uop_cnt
);

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t     state;
  logic [7:0] mask;
  logic [3:0] opcode;
  logic [7:0] imm8;
  logic       is_lmsm;
  logic       accept;
  logic       fire;
  logic [2:0] cur_reg;
  logic       cur_last;

  assign opcode  = instr_in[15:12];
  assign imm8    = instr_in[7:0];
  assign is_lmsm = (opcode == OP_LM) || (opcode == OP_SM);
  assign accept  = (state == IDLE) && instr_valid && is_lmsm && !flush;
  assign fire    = uop.uop_valid && uop.uop_ready && !flush;

  // Priority encoder over the registered mask: imm8[7] is R0 and wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_reg = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) cur_reg = 3'(7 - i);
    end
  end

  // Exactly one bit left: this micro-op closes the sequence.
  assign cur_last = (mask != 8'h00) && ((mask & (mask - 8'h01)) == 8'h00);

  assign uop.uop_reg  = cur_reg;
  assign uop.uop_last = cur_last;

  // Sequencer FSM: accept in IDLE, issue one micro-op per fire in ISSUE.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mask            <= 8'h00;
      uop.uop_valid   <= 1'b0;
      uop.uop_is_load <= 1'b0;
      uop.uop_addr    <= '0;
      busy            <= 1'b0;
      is_imm_zero_lm  <= 1'b0;
      is_imm_zero_sm  <= 1'b0;
    end else begin
      // Zero-imm indications are single-cycle pulses.
      is_imm_zero_lm <= 1'b0;
      is_imm_zero_sm <= 1'b0;
      if (flush) begin
        state         <= IDLE;
        mask          <= 8'h00;
        uop.uop_valid <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              mask            <= imm8;
              uop.uop_is_load <= (opcode == OP_LM);
              uop.uop_addr    <= base_addr;
              if (imm8 != 8'h00) begin
                state         <= ISSUE;
                uop.uop_valid <= 1'b1;
                busy          <= 1'b1;
              end else begin
                is_imm_zero_lm <= (opcode == OP_LM);
                is_imm_zero_sm <= (opcode == OP_SM);
              end
            end
          end
          ISSUE: begin
            // New LM/SM words are ignored here; the control unit holds IF/ID on busy.
            if (fire) begin
              mask         <= mask & ~(8'h80 >> cur_reg);
              uop.uop_addr <= uop.uop_addr + ADDR_W'(ADDR_STEP);
              if (cur_last) begin
                state         <= IDLE;
                uop.uop_valid <= 1'b0;
                busy          <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LMSM_STAT_EN
  // Completed micro-op counter; flushed uops and zero-imm pulses do not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_uop_cnt <= '0;
    end else if (fire) begin
      stat_uop_cnt <= stat_uop_cnt + STAT_W'(1);
    end
  end
`else
  assign stat_uop_cnt = '0;
`endif

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: directed cases plus randomized
// LM/SM sequences with random downstream back-pressure, compared against a
// queue of expected micro-ops derived from imm8 and the base address.
module tb_lmsm_sequencer;

  localparam int ADDR_W = 16;
  localparam int STAT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       instr_in;
  logic              instr_valid;
  logic [ADDR_W-1:0] base_addr;
  logic              flush;
  logic              busy;
  logic              is_imm_zero_lm;
  logic              is_imm_zero_sm;
  logic [STAT_W-1:0] stat_uop_cnt;

  lmsm_sequencer_if #(.ADDR_W(ADDR_W)) uop_bus ();

  lmsm_sequencer #(
    .ADDR_W   (ADDR_W),
    .ADDR_STEP(1),
    .STAT_W   (STAT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_in      (instr_in),
    .instr_valid   (instr_valid),
    .base_addr     (base_addr),
    .flush         (flush),
    .uop           (uop_bus.master),
    .busy          (busy),
    .is_imm_zero_lm(is_imm_zero_lm),
    .is_imm_zero_sm(is_imm_zero_sm),
    .stat_uop_cnt  (stat_uop_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  rix;
    logic [15:0] addr;
    logic        last;
  } uop_t;

  uop_t        exp_q[$];
  logic [15:0] exp_stat = 16'h0000;
  logic        exp_load;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] make_instr(logic is_load, logic [7:0] imm8);
    logic [2:0] ra;
    logic       pad;
    ra  = 3'($urandom);
    pad = 1'($urandom);
    return {(is_load ? 4'b0110 : 4'b0111), ra, pad, imm8};
  endfunction

  // Expected micro-ops: R0..R7 in order for each set bit, addresses base, base+1, ...
  function automatic void build_model(logic [7:0] imm8, logic [15:0] base);
    int n;
    int k;
    n = $countones(imm8);
    k = 0;
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      if (imm8[7-r]) begin
        uop_t u;
        u.rix  = 3'(r);
        u.addr = base + 16'(k);
        k++;
        u.last = (k == n);
        exp_q.push_back(u);
      end
    end
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef LMSM_STAT_EN
    return exp_stat;
`else
    return 16'h0000;
`endif
  endfunction

  // Present one LM/SM, then follow it to completion with back-pressure.
  task automatic run_seq(string name, logic is_load, logic [7:0] imm8, logic [15:0] base,
                         int pct, int stall_first);
    int   cyc;
    logic rdy;
    build_model(imm8, base);
    exp_load           = is_load;
    instr_in           = make_instr(is_load, imm8);
    instr_valid        = 1'b1;
    base_addr          = base;
    flush              = 1'b0;
    uop_bus.uop_ready  = 1'($urandom);
    step();
    instr_valid = 1'b0;
    base_addr   = 16'($urandom);
    if (imm8 == 8'h00) begin
      checks++;
      if (is_imm_zero_lm !== is_load || is_imm_zero_sm !== !is_load ||
          uop_bus.uop_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s zero_pulse: lm=%b sm=%b valid=%b busy=%b, expected lm=%b sm=%b valid=0 busy=0",
                 name, is_imm_zero_lm, is_imm_zero_sm, uop_bus.uop_valid, busy, is_load, !is_load);
      end
      step();
      checks++;
      if (is_imm_zero_lm !== 1'b0 || is_imm_zero_sm !== 1'b0 ||
          uop_bus.uop_valid !== 1'b0 || busy !== 1'b0 || stat_uop_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL %s zero_pulse_end: lm=%b sm=%b valid=%b busy=%b stat=%0d, expected 0 0 0 0 stat=%0d",
                 name, is_imm_zero_lm, is_imm_zero_sm, uop_bus.uop_valid, busy, stat_uop_cnt, exp_cnt());
      end
      return;
    end
    cyc = 0;
    while (exp_q.size() > 0) begin
      if (cyc >= 200) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: %0d uops still outstanding after %0d cycles", name, exp_q.size(), cyc);
        break;
      end
      checks++;
      if (uop_bus.uop_valid !== 1'b1 || busy !== 1'b1 || uop_bus.uop_reg !== exp_q[0].rix ||
          uop_bus.uop_addr !== exp_q[0].addr || uop_bus.uop_last !== exp_q[0].last ||
          uop_bus.uop_is_load !== exp_load || is_imm_zero_lm !== 1'b0 || is_imm_zero_sm !== 1'b0) begin
        errors++;
        $display("FAIL %s uop: valid=%b busy=%b reg=%0d addr=%h last=%b load=%b, expected valid=1 busy=1 reg=%0d addr=%h last=%b load=%b",
                 name, uop_bus.uop_valid, busy, uop_bus.uop_reg, uop_bus.uop_addr, uop_bus.uop_last,
                 uop_bus.uop_is_load, exp_q[0].rix, exp_q[0].addr, exp_q[0].last, exp_load);
      end
      rdy               = (cyc >= stall_first) && (int'($urandom_range(99)) < pct);
      uop_bus.uop_ready = rdy;
      // Unrelated instruction words while busy must be ignored.
      instr_valid = 1'($urandom);
      instr_in    = make_instr(1'($urandom), 8'($urandom));
      base_addr   = 16'($urandom);
      step();
      cyc++;
      if (rdy) begin
        void'(exp_q.pop_front());
        exp_stat++;
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (uop_bus.uop_valid !== 1'b0 || busy !== 1'b0 || stat_uop_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL %s done: valid=%b busy=%b stat=%0d, expected valid=0 busy=0 stat=%0d",
               name, uop_bus.uop_valid, busy, stat_uop_cnt, exp_cnt());
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    instr_valid = 1'b1;
    instr_in    = make_instr(1'b1, 8'hA5);
    base_addr   = 16'h1234;
    uop_bus.uop_ready = 1'b1;
    step();
    step();
    checks++;
    if (uop_bus.uop_valid !== 1'b0 || uop_bus.uop_is_load !== 1'b0 || uop_bus.uop_reg !== 3'd0 ||
        uop_bus.uop_addr !== 16'h0000 || uop_bus.uop_last !== 1'b0 || busy !== 1'b0 ||
        is_imm_zero_lm !== 1'b0 || is_imm_zero_sm !== 1'b0 || stat_uop_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset: valid=%b load=%b reg=%0d addr=%h last=%b busy=%b zlm=%b zsm=%b stat=%0d, expected all 0",
               uop_bus.uop_valid, uop_bus.uop_is_load, uop_bus.uop_reg, uop_bus.uop_addr, uop_bus.uop_last,
               busy, is_imm_zero_lm, is_imm_zero_sm, stat_uop_cnt);
    end
    rst         = 1'b0;
    instr_valid = 1'b0;
    exp_stat    = 16'h0000;
    step();
  endtask

  task automatic test_directed();
    run_seq("lm_a1", 1'b1, 8'b1010_0001, 16'h0040, 100, 0);
    run_seq("sm_zero", 1'b0, 8'h00, 16'h2222, 100, 0);
    run_seq("lm_zero", 1'b1, 8'h00, 16'h3333, 100, 0);
    run_seq("sm_wrap", 1'b0, 8'hFF, 16'hFFFE, 100, 0);
    run_seq("lm_stall", 1'b1, 8'h03, 16'h0100, 100, 2);
  endtask

  task automatic test_flush();
    logic [15:0] base;
    base = 16'($urandom);
    build_model(8'hF0, base);
    instr_in          = make_instr(1'b1, 8'hF0);
    instr_valid       = 1'b1;
    base_addr         = base;
    uop_bus.uop_ready = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    exp_stat++;
    void'(exp_q.pop_front());
    checks++;
    if (uop_bus.uop_valid !== 1'b1 || uop_bus.uop_reg !== exp_q[0].rix || uop_bus.uop_addr !== exp_q[0].addr) begin
      errors++;
      $display("FAIL flush_2nd_uop: valid=%b reg=%0d addr=%h, expected valid=1 reg=%0d addr=%h",
               uop_bus.uop_valid, uop_bus.uop_reg, uop_bus.uop_addr, exp_q[0].rix, exp_q[0].addr);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (uop_bus.uop_valid !== 1'b0 || busy !== 1'b0 || stat_uop_cnt !== exp_cnt()) begin
      errors++;
      $display("FAIL flush_kill: valid=%b busy=%b stat=%0d, expected valid=0 busy=0 stat=%0d",
               uop_bus.uop_valid, busy, stat_uop_cnt, exp_cnt());
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (uop_bus.uop_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet: valid=%b busy=%b, expected 0 0", uop_bus.uop_valid, busy);
      end
    end
  endtask

  task automatic test_flush_idle();
    instr_in    = make_instr(1'b0, 8'h00);
    instr_valid = 1'b1;
    flush       = 1'b1;
    step();
    checks++;
    if (is_imm_zero_sm !== 1'b0 || is_imm_zero_lm !== 1'b0) begin
      errors++;
      $display("FAIL flush_zero_accept: zlm=%b zsm=%b, expected 0 0", is_imm_zero_lm, is_imm_zero_sm);
    end
    instr_in = make_instr(1'b1, 8'h81);
    step();
    flush       = 1'b0;
    instr_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || uop_bus.uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_accept: busy=%b valid=%b, expected 0 0", busy, uop_bus.uop_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] base;
    base              = 16'($urandom);
    instr_in          = make_instr(1'b1, 8'hE7);
    instr_valid       = 1'b1;
    base_addr         = base;
    uop_bus.uop_ready = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst      = 1'b0;
    exp_stat = 16'h0000;
    checks++;
    if (uop_bus.uop_valid !== 1'b0 || uop_bus.uop_is_load !== 1'b0 || uop_bus.uop_reg !== 3'd0 ||
        uop_bus.uop_addr !== 16'h0000 || uop_bus.uop_last !== 1'b0 || busy !== 1'b0 ||
        stat_uop_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: valid=%b load=%b reg=%0d addr=%h last=%b busy=%b stat=%0d, expected all 0",
               uop_bus.uop_valid, uop_bus.uop_is_load, uop_bus.uop_reg, uop_bus.uop_addr,
               uop_bus.uop_last, busy, stat_uop_cnt);
    end
    run_seq("after_reset", 1'b1, 8'h5A, 16'h0800, 100, 0);
  endtask

  task automatic test_other_opcode();
    logic [3:0] op;
    for (int i = 0; i < 4; i++) begin
      op = 4'($urandom);
      while (op == 4'b0110 || op == 4'b0111) op = 4'($urandom);
      instr_in    = {op, 4'($urandom), 8'($urandom_range(1, 255))};
      instr_valid = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || uop_bus.uop_valid !== 1'b0 || is_imm_zero_lm !== 1'b0 || is_imm_zero_sm !== 1'b0) begin
        errors++;
        $display("FAIL other_opcode %h: busy=%b valid=%b zlm=%b zsm=%b, expected all 0",
                 op, busy, uop_bus.uop_valid, is_imm_zero_lm, is_imm_zero_sm);
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] imm8;
    for (int i = 0; i < 40; i++) begin
      imm8 = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      run_seq("random", 1'($urandom), imm8, 16'($urandom), int'($urandom_range(30, 100)), 0);
    end
  endtask

  initial begin
    rst               = 1'b1;
    instr_in          = 16'h0000;
    instr_valid       = 1'b0;
    base_addr         = 16'h0000;
    flush             = 1'b0;
    uop_bus.uop_ready = 1'b0;
    test_reset();
    test_directed();
    test_flush();
    test_flush_idle();
    test_reset_mid();
    test_other_opcode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
